// File: rtl/sparse_row_mac.sv
// Sparse-row MAC stage: multiplies CSR-ordered A elements by buffered dense B rows and emits one output row per A row.
// Optional SPARSE_ROW_MAC_SAT_EN selects saturating lane accumulation instead of wrap-around.
module sparse_row_mac #(
    parameter int M         = 16,
    parameter int N_COL     = 4,
    parameter int DW_DATA   = 8,
    parameter int DW_ROWIDX = 4,
    parameter int DW_ACC    = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_b_wr_en,
    input  logic [DW_ROWIDX-1:0]       i_b_wr_addr,
    input  logic [N_COL*DW_DATA-1:0]   i_b_wr_data,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic                       i_in_first,
    input  logic                       i_in_last,
    input  logic [DW_ROWIDX-1:0]       i_in_row,
    input  logic [DW_ROWIDX-1:0]       i_in_col,
    input  logic [DW_DATA-1:0]         i_in_val,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DW_ROWIDX-1:0]       o_out_row,
    output logic [N_COL*DW_ACC-1:0]    o_out_data,
    output logic                       o_busy
);

    localparam logic [DW_ROWIDX:0]  M_LIM   = (DW_ROWIDX+1)'(M);
    localparam logic signed [DW_ACC-1:0] ACC_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
    localparam logic signed [DW_ACC-1:0] ACC_MIN = {1'b1, {(DW_ACC-1){1'b0}}};

    function automatic logic signed [DW_ACC-1:0] acc_add(
        input logic signed [DW_ACC-1:0] a,
        input logic signed [DW_ACC-1:0] b
    );
`ifdef SPARSE_ROW_MAC_SAT_EN
        logic [DW_ACC:0] s;
        s = {a[DW_ACC-1], a} + {b[DW_ACC-1], b};
        if (s[DW_ACC] != s[DW_ACC-1]) begin
            acc_add = s[DW_ACC] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_add = s[DW_ACC-1:0];
        end
`else
        acc_add = a + b;
`endif
    endfunction

    logic [N_COL*DW_DATA-1:0]   r_bmem [M];
    logic [N_COL*DW_DATA-1:0]   r_brow;
    logic                       r_s1_valid;
    logic                       r_s1_first;
    logic                       r_s1_last;
    logic [DW_ROWIDX-1:0]       r_s1_row;
    logic signed [DW_DATA-1:0]  r_s1_val;
    logic                       r_s2_valid;
    logic signed [DW_ACC-1:0]   r_acc [N_COL];
    logic                       r_out_valid;
    logic [DW_ROWIDX-1:0]       r_out_row;
    logic [N_COL*DW_ACC-1:0]    r_out_data;

    logic                       w_stall;
    logic                       w_adv;
    logic signed [DW_ACC-1:0]   w_acc_next [N_COL];

    // A held output row freezes the whole pipe; a draining one lets it reload in place.
    assign w_stall     = r_out_valid & ~i_out_ready;
    assign w_adv       = ~w_stall;
    assign o_in_ready  = w_adv;
    assign o_busy      = r_s1_valid | r_s2_valid | r_out_valid;
    assign o_out_valid = r_out_valid;
    assign o_out_row   = r_out_row;
    assign o_out_data  = r_out_data;

    for (genvar j = 0; j < N_COL; j++) begin : g_lane
        logic signed [DW_DATA-1:0]   w_b;
        logic signed [2*DW_DATA-1:0] w_full;
        logic signed [DW_ACC-1:0]    w_prod;
        assign w_b           = $signed(r_brow[j*DW_DATA +: DW_DATA]);
        assign w_full        = r_s1_val * w_b;
        assign w_prod        = DW_ACC'(w_full);
        assign w_acc_next[j] = r_s1_first ? w_prod : acc_add(r_acc[j], w_prod);
    end

    // B row buffer write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (i_b_wr_en && ({1'b0, i_b_wr_addr} < M_LIM)) begin
            r_bmem[i_b_wr_addr] <= i_b_wr_data;
        end
    end

    // S1: capture the accepted element and read its B row (read-before-write on collision).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_row   <= '0;
            r_s1_val   <= '0;
            r_brow     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_first <= i_in_first;
                r_s1_last  <= i_in_last;
                r_s1_row   <= i_in_row;
                r_s1_val   <= i_in_val;
                r_brow     <= r_bmem[i_in_col];
            end
        end
    end

    // S2: per-lane accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            for (int j = 0; j < N_COL; j++) begin
                r_acc[j] <= '0;
            end
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                for (int j = 0; j < N_COL; j++) begin
                    r_acc[j] <= w_acc_next[j];
                end
            end
        end
    end

    // Output register: loads on a row's last element, clears once taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_data  <= '0;
        end else if (w_adv && r_s1_valid && r_s1_last) begin
            r_out_valid <= 1'b1;
            r_out_row   <= r_s1_row;
            for (int j = 0; j < N_COL; j++) begin
                r_out_data[j*DW_ACC +: DW_ACC] <= w_acc_next[j];
            end
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sparse_row_mac.sv
// Self-checking bench for sparse_row_mac (DW_ACC=16): directed table, corner sequences, randomized run vs. model.
module tb_sparse_row_mac;

    localparam int ACCW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        in_valid, in_ready, in_first, in_last;
    logic [3:0]  in_row, in_col;
    logic [7:0]  in_val;
    logic        out_valid, out_ready, busy;
    logic [3:0]  out_row;
    logic [63:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    sparse_row_mac #(.M(16), .N_COL(4), .DW_DATA(8), .DW_ROWIDX(4), .DW_ACC(ACCW)) dut (
        .clk(clk), .reset(reset),
        .i_b_wr_en(b_wr_en), .i_b_wr_addr(b_wr_addr), .i_b_wr_data(b_wr_data),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_first(in_first), .i_in_last(in_last),
        .i_in_row(in_row), .i_in_col(in_col), .i_in_val(in_val),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_row(out_row),
        .o_out_data(out_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        first;
        logic        last;
        logic [3:0]  row;
        logic [3:0]  col;
        int          val;
        logic        exp_v;
        logic [3:0]  exp_row;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vt[7];
    int   bm[16][4];
    int   macc[4];
    logic [3:0]  q_row[$];
    logic [63:0] q_data[$];

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] pack8(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic int fix(input int x);
`ifdef SPARSE_ROW_MAC_SAT_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
`else
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_b(input int addr, input int a, input int b, input int c, input int d);
        b_wr_en   = 1'b1;
        b_wr_addr = 4'(addr);
        b_wr_data = pack8(a, b, c, d);
        bm[addr][0] = a; bm[addr][1] = b; bm[addr][2] = c; bm[addr][3] = d;
        step();
        b_wr_en = 1'b0;
    endtask

    task automatic drive(input logic f, input logic l, input int row, input int col, input int val);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_row   = 4'(row);
        in_col   = 4'(col);
        in_val   = 8'(val);
    endtask

    task automatic send(input logic f, input logic l, input int row, input int col, input int val);
        drive(f, l, row, col, val);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int pos, len, rrow, cyc;
        logic pend;
        logic e_first, e_last;
        int e_row, e_col, e_val;
        int ex;

        reset = 1'b1; b_wr_en = 1'b0; b_wr_addr = 4'd0; b_wr_data = 32'd0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_row = 4'd0; in_col = 4'd0;
        in_val = 8'd0; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        wr_b(2, 1, 2, 3, 4);
        wr_b(0, 1, 1, 1, 1);
        wr_b(1, -2, 0, 2, 4);
        wr_b(4, 127, 127, 127, 127);
        wr_b(3, 0, 0, 0, 0);

        vt[0] = '{1'b1, 1'b1, 4'd5,  4'd2, 3,  1'b1, 4'd5,  pack4(3, 6, 9, 12)};
        vt[1] = '{1'b1, 1'b0, 4'd1,  4'd0, 5,  1'b0, 4'd0,  64'd0};
        vt[2] = '{1'b0, 1'b1, 4'd1,  4'd1, -3, 1'b1, 4'd1,  pack4(11, 5, -1, -7)};
        vt[3] = '{1'b1, 1'b0, 4'd7,  4'd2, -1, 1'b0, 4'd0,  64'd0};
        vt[4] = '{1'b0, 1'b1, 4'd7,  4'd0, 2,  1'b1, 4'd7,  pack4(1, 0, -1, -2)};
        vt[5] = '{1'b1, 1'b0, 4'd9,  4'd1, 4,  1'b0, 4'd0,  64'd0};
        vt[6] = '{1'b1, 1'b1, 4'd10, 4'd2, -2, 1'b1, 4'd10, pack4(-2, -4, -6, -8)};

        // Back-to-back elements; output for element i-1 appears after edge i.
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) drive(vt[i].first, vt[i].last, int'(vt[i].row), int'(vt[i].col), vt[i].val);
            else in_valid = 1'b0;
            step();
            if (i == 0) begin
                chk("tbl_lat_valid", 64'(out_valid), 64'd0);
            end else begin
                chk($sformatf("tbl%0d_valid", i - 1), 64'(out_valid), 64'(vt[i-1].exp_v));
                if (vt[i-1].exp_v) begin
                    chk($sformatf("tbl%0d_row", i - 1), 64'(out_row), 64'(vt[i-1].exp_row));
                    chk($sformatf("tbl%0d_data", i - 1), out_data, vt[i-1].exp_data);
                end
            end
        end
        in_valid = 1'b0;
        step();
        chk("tbl_idle_busy", 64'(busy), 64'd0);

        // Stall: two single-element rows held by out_ready=0, third waits on in_ready.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 2, 2, 1); step();
        drive(1'b1, 1'b1, 3, 2, 2); step();
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_row0", 64'(out_row), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 1'b1, 4, 0, 1);
        step(); step(); step();
        chk("stall_hold_row", 64'(out_row), 64'd2);
        chk("stall_hold_data", out_data, pack4(1, 2, 3, 4));
        chk("stall_hold_ready", 64'(in_ready), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("stall_next_valid", 64'(out_valid), 64'd1);
        chk("stall_next_row", 64'(out_row), 64'd3);
        chk("stall_next_data", out_data, pack4(2, 4, 6, 8));
        step();
        chk("stall_third_row", 64'(out_row), 64'd4);
        chk("stall_third_data", out_data, pack4(1, 1, 1, 1));
        step();
        chk("stall_drained", 64'(out_valid), 64'd0);
        chk("stall_busy_end", 64'(busy), 64'd0);

        // Three 127*127 products in one row.
        send(1'b1, 1'b0, 12, 4, 127);
        send(1'b0, 1'b0, 12, 4, 127);
        send(1'b0, 1'b1, 12, 4, 127);
        chk("ovf_not_yet", 64'(out_valid), 64'd0);
        step();
`ifdef SPARSE_ROW_MAC_SAT_EN
        ex = 32767;
`else
        ex = 48387 - 65536;
`endif
        chk("ovf_valid", 64'(out_valid), 64'd1);
        chk("ovf_data", out_data, pack4(ex, ex, ex, ex));

        // Write B[3] on the same edge an element reads it.
        b_wr_en = 1'b1; b_wr_addr = 4'd3; b_wr_data = pack8(7, 7, 7, 7);
        drive(1'b1, 1'b0, 13, 3, 2);
        step();
        b_wr_en = 1'b0;
        send(1'b0, 1'b1, 13, 3, 1);
        step();
        chk("rdw_row", 64'(out_row), 64'd13);
        chk("rdw_data", out_data, pack4(7, 7, 7, 7));
        for (int j = 0; j < 4; j++) bm[3][j] = 7;

        // Reset in the middle of a row.
        send(1'b1, 1'b0, 14, 2, 5);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        send(1'b0, 1'b1, 15, 2, 1);
        step();
        chk("post_rst_row", 64'(out_row), 64'd15);
        chk("post_rst_data", out_data, pack4(1, 2, 3, 4));

        // Randomized stream against a row-level model.
        for (int r = 0; r < 16; r++)
            wr_b(r, $urandom_range(255, 0) - 128, $urandom_range(255, 0) - 128,
                 $urandom_range(255, 0) - 128, $urandom_range(255, 0) - 128);
        reset = 1'b1; step(); reset = 1'b0;
        for (int j = 0; j < 4; j++) macc[j] = 0;
        pos = 0; len = 0; rrow = 0; pend = 1'b0;
        e_first = 1'b0; e_last = 1'b0; e_row = 0; e_col = 0; e_val = 0;
        for (cyc = 0; cyc < 1530; cyc++) begin
            if (!pend && cyc < 1500 && $urandom_range(3, 0) != 0) begin
                if (pos >= len) begin
                    rrow = $urandom_range(15, 0);
                    len  = $urandom_range(4, 1);
                    pos  = 0;
                end
                e_first = (pos == 0) && ($urandom_range(7, 0) != 0);
                e_last  = (pos == len - 1);
                e_row   = rrow;
                e_col   = $urandom_range(15, 0);
                e_val   = $urandom_range(255, 0) - 128;
                pos++;
                pend = 1'b1;
            end
            if (pend) drive(e_first, e_last, e_row, e_col, e_val);
            else in_valid = 1'b0;
            out_ready = (cyc >= 1500) ? 1'b1 : ($urandom_range(3, 0) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q_row.size() == 0) begin
                    chk("rand_unexpected_row", 64'(out_valid), 64'd0);
                end else begin
                    chk("rand_row", 64'(out_row), 64'(q_row.pop_front()));
                    chk("rand_data", out_data, q_data.pop_front());
                end
            end
            if (pend && in_ready) begin
                for (int j = 0; j < 4; j++) begin
                    ex = e_val * bm[e_col][j];
                    macc[j] = e_first ? fix(ex) : fix(macc[j] + ex);
                end
                if (e_last) begin
                    q_row.push_back(4'(e_row));
                    q_data.push_back(pack4(macc[0], macc[1], macc[2], macc[3]));
                end
                pend = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("rand_leftover", 64'(q_row.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
